ans_bcd_seq: RTL and testbench
==============================

ANS_BCD_SEQ -- requirements
Module: ans_bcd_seq

Interface
REQ-001 Parameter WIDTH, default 16, binary input width, 4..32.
REQ-002 Parameter DIGITS, default 5, decimal output digit count, 1..10.
REQ-003 Parameter SIGNED, default 1: 1 treats ans as two's complement; 0 treats it as unsigned.
REQ-004 The block uses one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  request conversion; sampled only in IDLE.
REQ-008 ans  in  WIDTH  value to convert; sampled on the accepting edge only.
REQ-009 busy  out  1  high while a conversion is in progress.
REQ-010 done  out  1  one-cycle pulse when results update.
REQ-011 sign  out  1  1 = negative input (SIGNED=1 only; always 0 when SIGNED=0).
REQ-012 bcd  out  4*DIGITS  packed BCD magnitude; digit i at bits [4i+3:4i]; digit 0 is the units digit.
REQ-013 blank  out  DIGITS  leading-zero mask; bit i=1 means digit i is a leading zero.
REQ-014 ovf  out  1  magnitude >= 10^DIGITS.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-016 In IDLE with start=1, the rising edge SHALL capture the magnitude and sign, clear the BCD accumulator, clear the internal overflow flag, load bit counter = WIDTH, and enter SHIFT.
REQ-017 Magnitude SHALL be ~ans+1 when SIGNED=1 and ans[WIDTH-1]=1, otherwise ans; held in WIDTH unsigned bits, so -2^(WIDTH-1) converts exactly.
REQ-018 Each SHIFT cycle SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, magnitude} left by one bit and decrement the counter.
REQ-019 A 1 shifted out of the top digit SHALL set the internal overflow flag (sticky for the conversion).
REQ-020 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE.
REQ-021 On the edge entering DONE, bcd, sign, ovf and blank SHALL update together.
REQ-022 done SHALL be high only during the DONE cycle; the FSM SHALL return to IDLE on the next edge.
REQ-023 Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH+1.
REQ-024 Back-to-back conversions SHALL be possible: start may be asserted in the first IDLE cycle after DONE.
REQ-025 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-026 start while busy=1 SHALL be ignored, with no queuing.
REQ-027 On overflow, bcd SHALL hold the low DIGITS decimal digits of the magnitude (magnitude mod 10^DIGITS) and ovf=1.
REQ-028 blank[i] SHALL be 1 iff digit i and all higher digits are 0, for i>=1.
REQ-029 blank[0] SHALL always be 0.
REQ-030 When ovf=1, blank SHALL be all 0.
REQ-031 Zero input SHALL give sign=0.
REQ-032 Outputs SHALL hold their last values between conversions; ans changes outside the accepting edge SHALL have no effect.

Reset
REQ-033 rst=1 SHALL force IDLE and set busy=0, done=0, sign=0, bcd=0, ovf=0, blank={DIGITS-1 ones, 0}, and the counter and accumulator to 0.
REQ-034 rst asserted mid-conversion SHALL abort the conversion, with no done pulse and no partial result visible.
REQ-035 rst SHALL take priority over start on the same edge.

Structure
REQ-036 The state encoding, the BCD digit width constant (4), and the add-3 threshold (5) SHALL live in shared package/header ans_pkg.
REQ-037 The per-digit correction (digit>=5 ? digit+3 : digit) SHALL be a sub-module bcd_add3_cell, instantiated DIGITS times via generate.
REQ-038 The counter width SHALL be clog2(WIDTH+1).

Verification (WIDTH=16, DIGITS=5, SIGNED=1 unless noted)
REQ-039 ans=16'd1234, start pulse -> done in the 18th cycle after start; bcd=20'h01234, sign=0, blank=5'b10000, ovf=0.
REQ-040 ans=16'hFFFF -> bcd=20'h00001, sign=1, blank=5'b11110.
REQ-041 ans=16'h8000 -> bcd=20'h32768, sign=1, blank=5'b00000.
REQ-042 ans=16'd0 -> bcd=0, sign=0, blank=5'b11110.
REQ-043 DIGITS=3, SIGNED=0, ans=16'd1234 -> bcd=12'h234, ovf=1, blank=3'b000.
REQ-044 Two sub-cases, both with ans=16'd1234 for the first start:
 - a second start with ans=16'd999 three cycles after the first start -> ignored; the result is 1234 and there is a single done pulse.
 - rst at cycle 8 of the conversion -> no done pulse; outputs at reset values.

Source files
------------

// File: rtl/ans_pkg.sv
// rtl/ans_pkg.sv - shared state encoding and BCD constants for the BCD sequencer
package ans_pkg;

  // One decimal digit occupies a nibble of the accumulator.
  localparam int BCD_W = 4;

  // Digits at or above this value get corrected before the next doubling.
  localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [BCD_W-1:0] ADD3_VAL    = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3_cell.sv
// rtl/bcd_add3_cell.sv - double-dabble correction for one BCD digit
module bcd_add3_cell
  import ans_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  // A digit of 5..9 would double past 9, so pre-add 3 to push the carry into the next digit.
  always_comb begin
    dout = din;
    if (din >= ADD3_THRESH) dout = din + ADD3_VAL;
  end

endmodule

// File: rtl/ans_bcd_seq.sv
// rtl/ans_bcd_seq.sv - sequential binary-to-BCD converter with sign, blanking and overflow
module ans_bcd_seq
  import ans_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        ans,
  output logic                    busy,
  output logic                    done,
  output logic                    sign,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]       blank,
  output logic                    ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = BCD_W * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_t state, state_nxt;

  logic [WIDTH-1:0]  mag;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_adj;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_int;
  logic              sign_int;
  logic              is_neg;
  logic [WIDTH-1:0]  mag_in;
  logic [DIGITS-1:0] blank_nxt;

  // Magnitude kept in WIDTH unsigned bits so the most negative value converts exactly.
  always_comb begin
    is_neg = (SIGNED != 0) && ans[WIDTH-1];
    mag_in = is_neg ? (~ans) + WIDTH'(1) : ans;
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_cell u_cell (
        .din  (acc[g*BCD_W +: BCD_W]),
        .dout (acc_adj[g*BCD_W +: BCD_W])
      );
    end
  endgenerate

  // Leading-zero mask: a digit is blank when it and every digit above it are zero; units never blank.
  always_comb begin
    logic hi_zero;
    blank_nxt = '0;
    hi_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero      = hi_zero && (acc[i*BCD_W +: BCD_W] == '0);
      blank_nxt[i] = hi_zero;
    end
    if (ovf_int) blank_nxt = '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs; SHIFT lingers one extra cycle at cnt==0 to publish results.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, correct-then-shift per bit, publish all results on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag      <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_int  <= 1'b0;
      sign_int <= 1'b0;
      bcd      <= '0;
      sign     <= 1'b0;
      ovf      <= 1'b0;
      blank    <= BLANK_RST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mag      <= mag_in;
            sign_int <= is_neg;
            acc      <= '0;
            ovf_int  <= 1'b0;
            cnt      <= CNT_W'(WIDTH);
          end
        end
        ST_SHIFT: begin
          if (cnt != '0) begin
            acc     <= {acc_adj[ACC_W-2:0], mag[WIDTH-1]};
            mag     <= {mag[WIDTH-2:0], 1'b0};
            ovf_int <= ovf_int | acc_adj[ACC_W-1];
            cnt     <= cnt - CNT_W'(1);
          end else begin
            bcd   <= acc;
            sign  <= sign_int;
            ovf   <= ovf_int;
            blank <= blank_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ans_bcd_seq.sv
// tb/tb_ans_bcd_seq.sv - self-checking bench for ans_bcd_seq (5-digit signed and 3-digit unsigned)
module tb_ans_bcd_seq;

  typedef struct packed {
    logic [15:0] a;
    logic        sign;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        ovf;
    logic [11:0] bcd3;
    logic [2:0]  blank3;
    logic        ovf3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] ans;

  logic        busy, done, sign, ovf;
  logic [19:0] bcd;
  logic [4:0]  blank;
  logic        busy3, done3, sign3, ovf3;
  logic [11:0] bcd3;
  logic [2:0]  blank3;

  int checks = 0;
  int errors = 0;

  ans_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) dut (
    .clk(clk), .rst(rst), .start(start), .ans(ans),
    .busy(busy), .done(done), .sign(sign), .bcd(bcd), .blank(blank), .ovf(ovf)
  );

  ans_bcd_seq #(.WIDTH(16), .DIGITS(3), .SIGNED(0)) dut3 (
    .clk(clk), .rst(rst), .start(start), .ans(ans),
    .busy(busy3), .done(done3), .sign(sign3), .bcd(bcd3), .blank(blank3), .ovf(ovf3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the magnitude.
  function automatic void model(input logic [15:0] a, input int digits, input bit sgn,
                                output logic s, output logic [39:0] b,
                                output logic [9:0] bl, output logic o);
    longint mag, lim, m, p;
    s   = sgn && a[15];
    mag = s ? (longint'(65536) - longint'(a)) : longint'(a);
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    o = (mag >= lim);
    m = mag % lim;
    b = '0;
    bl = '0;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      b[4*i +: 4] = 4'((m / p) % 10);
      if (i >= 1 && !o && (m / p) == 0) bl[i] = 1'b1;
      p = p * 10;
    end
  endfunction

  function automatic vec_t model_vec(input logic [15:0] a);
    vec_t v;
    logic s, o;
    logic [39:0] b;
    logic [9:0] bl;
    v.a = a;
    model(a, 5, 1'b1, s, b, bl, o);
    v.sign = s; v.bcd = b[19:0]; v.blank = bl[4:0]; v.ovf = o;
    model(a, 3, 1'b0, s, b, bl, o);
    v.bcd3 = b[11:0]; v.blank3 = bl[2:0]; v.ovf3 = o;
    return v;
  endfunction

  task automatic chk_results(input vec_t v);
    chk("sign", 64'(sign), 64'(v.sign));
    chk("bcd", 64'(bcd), 64'(v.bcd));
    chk("blank", 64'(blank), 64'(v.blank));
    chk("ovf", 64'(ovf), 64'(v.ovf));
    chk("sign3", 64'(sign3), 64'(0));
    chk("bcd3", 64'(bcd3), 64'(v.bcd3));
    chk("blank3", 64'(blank3), 64'(v.blank3));
    chk("ovf3", 64'(ovf3), 64'(v.ovf3));
  endtask

  task automatic chk_reset_state();
    chk("rst_busy", 64'({busy, busy3}), 64'(0));
    chk("rst_done", 64'({done, done3}), 64'(0));
    chk("rst_sign", 64'({sign, sign3}), 64'(0));
    chk("rst_bcd", 64'({bcd, bcd3}), 64'(0));
    chk("rst_ovf", 64'({ovf, ovf3}), 64'(0));
    chk("rst_blank", 64'(blank), 64'(5'b11110));
    chk("rst_blank3", 64'(blank3), 64'(3'b110));
  endtask

  // Called just after a negedge in IDLE; returns just after the negedge of the first IDLE cycle.
  task automatic convert(input vec_t v);
    int  lat;
    logic busy_ok;
    start = 1'b1;
    ans   = v.a;
    @(posedge clk);
    #1;
    start = 1'b0;
    ans   = 16'($urandom);
    lat     = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (!busy || !busy3) busy_ok = 1'b0;
      ans = 16'($urandom);
    end
    chk("latency", 64'(lat), 64'(18));
    chk("busy_during", 64'(busy_ok), 64'(1));
    chk("done3_with_done", 64'(done3), 64'(1));
    chk_results(v);
    @(negedge clk);
    chk("done_pulse_1cyc", 64'(done), 64'(0));
    chk("busy_after", 64'(busy), 64'(0));
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    int   lat, dones;
    logic done_seen;

    tbl[0] = '{16'd1234, 1'b0, 20'h01234, 5'b10000, 1'b0, 12'h234, 3'b000, 1'b1};
    tbl[1] = '{16'hFFFF, 1'b1, 20'h00001, 5'b11110, 1'b0, 12'h535, 3'b000, 1'b1};
    tbl[2] = '{16'h8000, 1'b1, 20'h32768, 5'b00000, 1'b0, 12'h768, 3'b000, 1'b1};
    tbl[3] = '{16'd0,    1'b0, 20'h00000, 5'b11110, 1'b0, 12'h000, 3'b110, 1'b0};
    tbl[4] = '{16'd999,  1'b0, 20'h00999, 5'b11000, 1'b0, 12'h999, 3'b000, 1'b0};
    tbl[5] = '{16'h7FFF, 1'b0, 20'h32767, 5'b00000, 1'b0, 12'h767, 3'b000, 1'b1};
    tbl[6] = '{16'd1000, 1'b0, 20'h01000, 5'b10000, 1'b0, 12'h000, 3'b000, 1'b1};
    tbl[7] = '{16'd5,    1'b0, 20'h00005, 5'b11110, 1'b0, 12'h005, 3'b110, 1'b0};

    rst = 1'b1; start = 1'b0; ans = '0;
    repeat (3) @(negedge clk);
    chk_reset_state();
    rst = 1'b0;

    // Hand-derived vectors, issued back-to-back.
    for (int i = 0; i < 8; i++) convert(tbl[i]);

    // Randomized vectors against the reference, with idle gaps and idle-time ans noise.
    for (int i = 0; i < 30; i++) begin
      v = model_vec(16'($urandom));
      convert(v);
      repeat ($urandom_range(0, 2)) begin
        ans = 16'($urandom);
        @(negedge clk);
      end
      chk("hold_bcd", 64'({bcd, bcd3}), 64'({v.bcd, v.bcd3}));
    end

    // Second start during a conversion is dropped.
    v = tbl[0];
    start = 1'b1; ans = 16'd1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0; dones = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 3) begin start = 1'b1; ans = 16'd999; end
      if (n == 4) start = 1'b0;
      if (done) begin
        dones++;
        if (lat == 0) lat = n;
        chk_results(v);
      end
    end
    chk("ignored_start_lat", 64'(lat), 64'(18));
    chk("ignored_start_dones", 64'(dones), 64'(1));

    // Reset in cycle 8 of a conversion aborts it.
    start = 1'b1; ans = 16'd1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state();
    done_seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || done3) done_seen = 1'b1;
    end
    chk("abort_no_done", 64'(done_seen), 64'(0));
    chk_reset_state();

    // Reset wins over start on the same edge.
    rst = 1'b1; start = 1'b1; ans = 16'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_over_start", 64'({busy, busy3}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
